// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a frame FSM drives a parallel-to-serial shift register,
// and a bit-period counter sets how long each bit is held on the line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [CNT_W-1:0]     clk_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 serial_out_r;
  logic                 tx_busy_r;
  logic                 tx_done_r;
  logic                 period_end_s;

  assign period_end_s = (clk_cnt_r == CNT_LAST);
  assign serial_out   = serial_out_r;
  assign tx_busy      = tx_busy_r;
  assign tx_done      = tx_done_r;

  // Frame sequencer; the line level is registered one step ahead so every bit
  // appears on the edge that begins its period.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      clk_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      serial_out_r <= 1'b1;
      tx_busy_r    <= 1'b0;
      tx_done_r    <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_start) begin
            shift_r      <= tx_data;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            serial_out_r <= 1'b0;
            tx_busy_r    <= 1'b1;
            state_r      <= START;
          end else begin
            serial_out_r <= 1'b1;
            tx_busy_r    <= 1'b0;
          end
        end
        START: begin
          if (period_end_s) begin
            clk_cnt_r    <= '0;
            serial_out_r <= shift_r[0];
            state_r      <= DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (period_end_s) begin
            clk_cnt_r <= '0;
            shift_r   <= shift_r >> 1;
            bit_cnt_r <= bit_cnt_r + 1'b1;
            if (bit_cnt_r == BIT_LAST) begin
              serial_out_r <= 1'b1;
              state_r      <= STOP;
            end else begin
              // bit 1 becomes bit 0 after this shift
              serial_out_r <= shift_r[1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (period_end_s) begin
            clk_cnt_r <= '0;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          clk_cnt_r    <= '0;
          serial_out_r <= 1'b1;
          tx_busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts one parallel byte per request and serializes it onto a single output line as an 8N1 frame. The frame is one low start bit, DATA_BITS data bits LSB first, and one high stop bit. Every bit is held for a programmable number of clock cycles. It is the transmit-side counterpart of the receive path, which samples the line and collects bits through the serial-to-parallel shift register. An internal parallel-to-serial shift register is paired with a bit-period counter and a frame FSM.

## Interface
Parameters:
- CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5–9.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  transmit request; sampled only while idle.
- tx_data  in  DATA_BITS  byte to send; captured on the accepting edge.
- serial_out  out  1  UART line; idles high.
- tx_busy  out  1  high from the accepting edge until the frame completes.
- tx_done  out  1  one-cycle pulse when a frame completes.

## Operation
- All outputs are registered.
- Reset (async, while n_rst=0) forces:
  - state=IDLE, serial_out=1, tx_busy=0, tx_done=0;
  - shift register and counters to 0.
- FSM states:
  - IDLE: serial_out=1. On tx_start=1, latch tx_data into the shift register, clear both counters, and go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: serial_out = shift register bit 0. At the end of each bit period, shift right by one and increment the bit counter. After DATA_BITS bits, go to STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- Bit-period counter:
  - counts 0..CLKS_PER_BIT-1;
  - wraps to 0 at the end of each bit period;
  - width $clog2(CLKS_PER_BIT).
- Bit counter width is $clog2(DATA_BITS+1).
- tx_start while tx_busy=1 is ignored; tx_data changes while busy do not affect the frame in flight.
- tx_start held high continuously sends back-to-back frames, each re-capturing tx_data on its accepting edge.
- Reset asserted mid-frame: the line returns high immediately (asynchronously). The partial frame is abandoned, and no tx_done is produced.

## Timing
Let C = CLKS_PER_BIT, D = DATA_BITS, and let edge k be the edge that samples tx_start=1 in IDLE.
- After edge k: tx_busy=1 and serial_out=0 (start bit). There is no extra latency.
- After edge k+C·(1+i): serial_out = tx_data[i], for i = 0..D-1.
- After edge k+C·(1+D): serial_out=1 (stop bit).
- After edge k+C·(2+D):
  - state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle;
  - serial_out remains 1.
- Total frame length is C·(D+2) cycles.
- The earliest next acceptance is edge k+C·(2+D)+1. The line therefore idles at least one cycle beyond the stop bit: C+1 high cycles minimum between consecutive start bits.
- tx_done and tx_busy never both equal 1.

## Test plan
- **Reset:** assert n_rst=0 mid-DATA with tx_data=8'h00 in flight. Required: serial_out=1 and tx_busy=0 asynchronously, before the next clk edge, and tx_done stays 0.
- **Single frame:** C=10, tx_data=8'hA5, tx_start pulsed for 1 cycle. Required, each level held exactly 10 cycles: 0, then 1,0,1,0,0,1,0,1, then 1. tx_done pulses once, 100 cycles after acceptance.
- **Edge data values:** send 8'h00, then 8'hFF. Required:
  - for 8'h00, the line is low for 90 consecutive cycles;
  - for 8'hFF, it is low for only the 10-cycle start bit;
  - stop bits are high in both frames.
- **Request while busy:** send 8'h3C, then pulse tx_start with tx_data=8'hFF at cycle 40 of the frame. Required: the frame still carries 8'h3C, and no second frame starts.
- **Back-to-back:** hold tx_start=1 with tx_data=8'h55 for two frames. Required:
  - two 8'h55 frames;
  - the second start bit begins 101 cycles after the first;
  - tx_done pulses twice.
- **Parameter sweep:** C=2 and D=5, tx_data=5'b10011. Required: line sequence 0,1,1,0,0,1,1 with each bit held 2 cycles, for a 14-cycle frame.
